// File: rtl/parking_pkg.sv
// Shared types and helpers for the multi-lane parking occupancy counter.
package parking_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    IN1        = 3'd1,
    IN2        = 3'd2,
    IN3        = 3'd3,
    OUT1       = 3'd4,
    OUT2       = 3'd5,
    OUT3       = 3'd6,
    WAIT_CLEAR = 3'd7
  } lane_state_t;

  // Lane vectors are zero-extended to 8 bits (the maximum lane count) before counting.
  function automatic logic [3:0] popcount(input logic [7:0] v);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < 8; i++) begin
      c = c + 4'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/parking_lot_counter_lane.sv
// One lane: sensor synchronisers, debouncers, pass-sequence FSM and mid-sequence timeout.
module lane_direction_fsm
  import parking_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int TIMEOUT_CYCLES  = 1_000_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic s1,
  input  logic s2,
  output logic entry_pulse,
  output logic exit_pulse,
  output logic fault
);

  localparam int DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [1:0] raw;
  logic [1:0] sync_p0;
  logic [1:0] sync_p1;
  logic [1:0] deb_p2;
  logic [DB_W-1:0] db_cnt [2];

  assign raw = {s2, s1};

  // Stage p0/p1: two-flop synchroniser per sensor
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
    end
  end

  // Stage p2: accepted level moves only after DEBOUNCE_CYCLES consecutive differing samples
  for (genvar k = 0; k < 2; k++) begin : g_deb
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        db_cnt[k] <= '0;
        deb_p2[k] <= 1'b0;
      end else if (sync_p1[k] == deb_p2[k]) begin
        db_cnt[k] <= '0;
      end else if (db_cnt[k] == DB_LAST) begin
        db_cnt[k] <= '0;
        deb_p2[k] <= sync_p1[k];
      end else begin
        db_cnt[k] <= db_cnt[k] + 1'b1;
      end
    end
  end

  logic a;
  logic b;
  assign a = deb_p2[0];
  assign b = deb_p2[1];

  lane_state_t state;
  lane_state_t state_next;
  logic [TMO_W-1:0] tmo_cnt;
  logic active;
  logic timed_out;
  logic entry_set;
  logic exit_set;

  assign active    = (state != IDLE) && (state != WAIT_CLEAR);
  assign timed_out = active && (tmo_cnt == TMO_LAST);

  always_comb begin
    state_next = state;
    entry_set  = 1'b0;
    exit_set   = 1'b0;
    case (state)
      IDLE: begin
        if (a && !b)       state_next = IN1;
        else if (!a && b)  state_next = OUT1;
        else if (a && b)   state_next = WAIT_CLEAR;
      end
      IN1: begin
        if (a && b)        state_next = IN2;
        else if (!a && !b) state_next = IDLE;
      end
      IN2: begin
        if (!a && b)       state_next = IN3;
        else if (a && !b)  state_next = IN1;
        else if (!a && !b) state_next = IDLE;
      end
      IN3: begin
        if (!a && !b) begin
          state_next = IDLE;
          entry_set  = 1'b1;
        end else if (a && b) begin
          state_next = IN2;
        end
      end
      OUT1: begin
        if (a && b)        state_next = OUT2;
        else if (!a && !b) state_next = IDLE;
      end
      OUT2: begin
        if (a && !b)       state_next = OUT3;
        else if (!a && b)  state_next = OUT1;
        else if (!a && !b) state_next = IDLE;
      end
      OUT3: begin
        if (!a && !b) begin
          state_next = IDLE;
          exit_set   = 1'b1;
        end else if (a && b) begin
          state_next = OUT2;
        end
      end
      WAIT_CLEAR: begin
        if (!a && !b)      state_next = IDLE;
      end
      default:             state_next = IDLE;
    endcase
    // A stuck lane is parked until both sensors release; no event may escape.
    if (timed_out) begin
      state_next = WAIT_CLEAR;
      entry_set  = 1'b0;
      exit_set   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      tmo_cnt     <= '0;
      entry_pulse <= 1'b0;
      exit_pulse  <= 1'b0;
      fault       <= 1'b0;
    end else begin
      state       <= state_next;
      entry_pulse <= entry_set;
      exit_pulse  <= exit_set;
      if (state_next != state) begin
        tmo_cnt <= '0;
      end else if (active) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
      if (timed_out) begin
        fault <= 1'b1;
      end else if (state == WAIT_CLEAR && state_next == IDLE) begin
        fault <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/parking_lot_counter.sv
// Multi-lane parking counter: per-lane direction FSMs merged into one saturating occupancy count.
module parking_lot_counter
  import parking_pkg::*;
#(
  parameter int N_LANES         = 2,
  parameter int CAPACITY        = 99,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int TIMEOUT_CYCLES  = 1_000_000_000,
  parameter int CNT_W           = $clog2(CAPACITY + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_LANES-1:0] s1,
  input  logic [N_LANES-1:0] s2,
  input  logic               clear,
  output logic [CNT_W-1:0]   occ_count,
  output logic               full,
  output logic               empty,
  output logic [N_LANES-1:0] lane_entry,
  output logic [N_LANES-1:0] lane_exit,
  output logic [N_LANES-1:0] lane_fault,
  output logic               reject_full,
  output logic               reject_empty
);

  localparam int SUM_W = CNT_W + 4;
  localparam logic signed [SUM_W-1:0] CAP_S = signed'(SUM_W'(CAPACITY));

  for (genvar i = 0; i < N_LANES; i++) begin : g_lane
    lane_direction_fsm #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_lane (
      .clk        (clk),
      .rst_n      (rst_n),
      .s1         (s1[i]),
      .s2         (s2[i]),
      .entry_pulse(lane_entry[i]),
      .exit_pulse (lane_exit[i]),
      .fault      (lane_fault[i])
    );
  end

  function automatic logic [CNT_W-1:0] sat_occ(input logic signed [SUM_W-1:0] v);
    if (v > CAP_S)      return CNT_W'(CAPACITY);
    else if (v < 0)     return '0;
    else                return v[CNT_W-1:0];
  endfunction

  logic [3:0] n_in;
  logic [3:0] n_out;
  logic signed [SUM_W-1:0] sum_p0;

  assign n_in  = popcount(8'(lane_entry));
  assign n_out = popcount(8'(lane_exit));

  // Entries and exits of the same cycle net out before clamping.
  assign sum_p0 = $signed({4'b0000, occ_count})
                + $signed({{CNT_W{1'b0}}, n_in})
                - $signed({{CNT_W{1'b0}}, n_out});

  // Stage p1: registered occupancy and reject pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_count    <= '0;
      reject_full  <= 1'b0;
      reject_empty <= 1'b0;
    end else if (clear) begin
      occ_count    <= '0;
      reject_full  <= 1'b0;
      reject_empty <= 1'b0;
    end else begin
      occ_count    <= sat_occ(sum_p0);
      reject_full  <= (sum_p0 > CAP_S);
      reject_empty <= (sum_p0 < 0);
    end
  end

  assign full  = (occ_count == CNT_W'(CAPACITY));
  assign empty = (occ_count == '0);

endmodule

// File: tb/tb_parking_lot_counter.sv
// Directed self-checking bench for parking_lot_counter (2 lanes, capacity 5, short debounce/timeout).
module tb_parking_lot_counter;

  localparam int NL = 2;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NL-1:0] s1;
  logic [NL-1:0] s2;
  logic          clear;
  logic [CW-1:0] occ_count;
  logic          full;
  logic          empty;
  logic [NL-1:0] lane_entry;
  logic [NL-1:0] lane_exit;
  logic [NL-1:0] lane_fault;
  logic          reject_full;
  logic          reject_empty;

  parking_lot_counter #(
    .N_LANES(2), .CAPACITY(5), .DEBOUNCE_CYCLES(4), .TIMEOUT_CYCLES(200)
  ) dut (
    .clk(clk), .rst_n(rst_n), .s1(s1), .s2(s2), .clear(clear),
    .occ_count(occ_count), .full(full), .empty(empty),
    .lane_entry(lane_entry), .lane_exit(lane_exit), .lane_fault(lane_fault),
    .reject_full(reject_full), .reject_empty(reject_empty)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int n_entry [NL];
  int n_exit  [NL];
  int n_rf = 0;
  int n_re = 0;

  // {a,b} per step: entry is S1, S1&S2, S2, none; exit is the mirror.
  logic [1:0] seq_in  [4] = '{2'b10, 2'b11, 2'b01, 2'b00};
  logic [1:0] seq_out [4] = '{2'b01, 2'b11, 2'b10, 2'b00};

  initial begin
    for (int i = 0; i < NL; i++) begin
      n_entry[i] = 0;
      n_exit[i]  = 0;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < NL; i++) begin
        if (lane_entry[i]) n_entry[i]++;
        if (lane_exit[i])  n_exit[i]++;
      end
      if (reject_full)  n_rf++;
      if (reject_empty) n_re++;
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_lane(input int ln, input logic [1:0] ab);
    s1[ln] = ab[1];
    s2[ln] = ab[0];
  endtask

  task automatic pass_lane(input int ln, input bit is_entry);
    for (int st = 0; st < 4; st++) begin
      set_lane(ln, is_entry ? seq_in[st] : seq_out[st]);
      wait_cyc(10);
    end
    wait_cyc(5);
  endtask

  task automatic pass_both(input bit e0, input bit e1);
    for (int st = 0; st < 4; st++) begin
      set_lane(0, e0 ? seq_in[st] : seq_out[st]);
      set_lane(1, e1 ? seq_in[st] : seq_out[st]);
      wait_cyc(10);
    end
    wait_cyc(5);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; s1 = '0; s2 = '0; clear = 1'b0;
    wait_cyc(3);
    tests++;
    if (occ_count !== 3'd0 || empty !== 1'b1 || full !== 1'b0) begin
      fails++;
      $display("FAIL reset_flags: occ=%0d empty=%b full=%b, expected occ=0 empty=1 full=0", occ_count, empty, full);
    end
    tests++;
    if (lane_entry !== 2'b00 || lane_exit !== 2'b00 || lane_fault !== 2'b00 || reject_full !== 1'b0 || reject_empty !== 1'b0) begin
      fails++;
      $display("FAIL reset_pulses: entry=%b exit=%b fault=%b rf=%b re=%b, expected all 0", lane_entry, lane_exit, lane_fault, reject_full, reject_empty);
    end
    rst_n = 1'b1;
    wait_cyc(2);
  endtask

  task automatic test_entry();
    int seen;
    seen = 0;
    for (int st = 0; st < 3; st++) begin
      set_lane(0, seq_in[st]);
      wait_cyc(10);
    end
    set_lane(0, 2'b00);
    for (int c = 0; c < 20 && seen == 0; c++) begin
      @(negedge clk);
      if (lane_entry[0]) seen = 1;
    end
    tests++;
    if (seen != 1) begin
      fails++;
      $display("FAIL entry_pulse: pulse seen=%0d, expected 1 within 20 cycles", seen);
    end
    tests++;
    if (occ_count !== 3'd0) begin
      fails++;
      $display("FAIL entry_latency_same: occ=%0d during pulse, expected 0", occ_count);
    end
    @(negedge clk);
    tests++;
    if (occ_count !== 3'd1 || empty !== 1'b0) begin
      fails++;
      $display("FAIL entry_count: occ=%0d empty=%b, expected occ=1 empty=0", occ_count, empty);
    end
    wait_cyc(5);
    tests++;
    if (n_entry[0] != 1 || n_exit[0] != 0) begin
      fails++;
      $display("FAIL entry_once: entries=%0d exits=%0d, expected 1 and 0", n_entry[0], n_exit[0]);
    end
  endtask

  task automatic test_backout();
    int e0, x0;
    e0 = n_entry[0]; x0 = n_exit[0];
    set_lane(0, 2'b10); wait_cyc(10);
    set_lane(0, 2'b11); wait_cyc(10);
    set_lane(0, 2'b10); wait_cyc(10);
    set_lane(0, 2'b00); wait_cyc(15);
    tests++;
    if (n_entry[0] != e0 || n_exit[0] != x0 || occ_count !== 3'd1) begin
      fails++;
      $display("FAIL backout: entries+%0d exits+%0d occ=%0d, expected +0 +0 occ=1", n_entry[0]-e0, n_exit[0]-x0, occ_count);
    end
    // Short S1 glitches must leave the lane in IDLE, so an exit pass still counts.
    for (int g = 0; g < 3; g++) begin
      s1[0] = 1'b1; wait_cyc(2);
      s1[0] = 1'b0; wait_cyc(4);
    end
    pass_lane(0, 1'b0);
    tests++;
    if (n_exit[0] != x0 + 1 || occ_count !== 3'd0 || empty !== 1'b1) begin
      fails++;
      $display("FAIL glitch_idle: exits+%0d occ=%0d empty=%b, expected +1 occ=0 empty=1", n_exit[0]-x0, occ_count, empty);
    end
  endtask

  task automatic test_saturation();
    int rf, re;
    for (int k = 0; k < 5; k++) pass_lane(0, 1'b1);
    tests++;
    if (occ_count !== 3'd5 || full !== 1'b1 || empty !== 1'b0) begin
      fails++;
      $display("FAIL preload: occ=%0d full=%b empty=%b, expected 5 1 0", occ_count, full, empty);
    end
    rf = n_rf;
    pass_lane(0, 1'b1);
    tests++;
    if (occ_count !== 3'd5 || full !== 1'b1 || n_rf != rf + 1) begin
      fails++;
      $display("FAIL sat_full: occ=%0d full=%b rejects+%0d, expected 5 1 +1", occ_count, full, n_rf-rf);
    end
    clear = 1'b1; @(negedge clk); clear = 1'b0;
    tests++;
    if (occ_count !== 3'd0 || empty !== 1'b1) begin
      fails++;
      $display("FAIL clear: occ=%0d empty=%b, expected 0 1", occ_count, empty);
    end
    re = n_re;
    pass_lane(0, 1'b0);
    tests++;
    if (occ_count !== 3'd0 || n_re != re + 1) begin
      fails++;
      $display("FAIL sat_empty: occ=%0d rejects+%0d, expected 0 +1", occ_count, n_re-re);
    end
  endtask

  task automatic test_simultaneous();
    int rf, e0, x1;
    for (int k = 0; k < 5; k++) pass_lane(0, 1'b1);
    rf = n_rf; e0 = n_entry[0]; x1 = n_exit[1];
    pass_both(1'b1, 1'b0);
    tests++;
    if (occ_count !== 3'd5 || n_rf != rf || n_entry[0] != e0 + 1 || n_exit[1] != x1 + 1) begin
      fails++;
      $display("FAIL net_at_cap: occ=%0d rejects+%0d entry0+%0d exit1+%0d, expected 5 +0 +1 +1", occ_count, n_rf-rf, n_entry[0]-e0, n_exit[1]-x1);
    end
    pass_lane(1, 1'b0);
    tests++;
    if (occ_count !== 3'd4) begin
      fails++;
      $display("FAIL lane1_exit: occ=%0d, expected 4", occ_count);
    end
    rf = n_rf;
    pass_both(1'b1, 1'b1);
    tests++;
    if (occ_count !== 3'd5 || full !== 1'b1 || n_rf != rf + 1) begin
      fails++;
      $display("FAIL double_entry: occ=%0d full=%b rejects+%0d, expected 5 1 +1", occ_count, full, n_rf-rf);
    end
  endtask

  task automatic test_timeout();
    int e1, x1;
    e1 = n_entry[1]; x1 = n_exit[1];
    set_lane(1, 2'b10);
    wait_cyc(100);
    tests++;
    if (lane_fault !== 2'b00) begin
      fails++;
      $display("FAIL fault_early: fault=%b, expected 00", lane_fault);
    end
    wait_cyc(150);
    tests++;
    if (lane_fault !== 2'b10) begin
      fails++;
      $display("FAIL fault_set: fault=%b, expected 10", lane_fault);
    end
    set_lane(1, 2'b00);
    wait_cyc(20);
    tests++;
    if (lane_fault !== 2'b00 || n_entry[1] != e1 || n_exit[1] != x1 || occ_count !== 3'd5) begin
      fails++;
      $display("FAIL fault_clear: fault=%b entry1+%0d exit1+%0d occ=%0d, expected 00 +0 +0 5", lane_fault, n_entry[1]-e1, n_exit[1]-x1, occ_count);
    end
  endtask

  task automatic test_reset_mid();
    int e0, x0;
    set_lane(0, 2'b10); wait_cyc(10);
    set_lane(0, 2'b11); wait_cyc(10);
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (occ_count !== 3'd0 || empty !== 1'b1 || full !== 1'b0 || lane_fault !== 2'b00 || lane_entry !== 2'b00 || lane_exit !== 2'b00) begin
      fails++;
      $display("FAIL async_reset: occ=%0d empty=%b full=%b fault=%b entry=%b exit=%b, expected 0 1 0 00 00 00", occ_count, empty, full, lane_fault, lane_entry, lane_exit);
    end
    wait_cyc(3);
    rst_n = 1'b1;
    e0 = n_entry[0]; x0 = n_exit[0];
    wait_cyc(10);
    set_lane(0, 2'b01); wait_cyc(10);
    set_lane(0, 2'b00); wait_cyc(15);
    tests++;
    if (n_entry[0] != e0 || n_exit[0] != x0 || occ_count !== 3'd0) begin
      fails++;
      $display("FAIL reset_no_event: entry0+%0d exit0+%0d occ=%0d, expected +0 +0 0", n_entry[0]-e0, n_exit[0]-x0, occ_count);
    end
  endtask

  initial begin
    test_reset();
    test_entry();
    test_backout();
    test_saturation();
    test_simultaneous();
    test_timeout();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/parking_lot_counter.md
Name: parking_lot_counter

Overview:
Multi-lane successor to the single-lane vehicle counter. Each of N_LANES lanes has an outer (S1) and inner (S2) presence sensor. A per-lane FSM debounces the sensors, tracks the full pass sequence, and reports confirmed entries and exits. A shared saturating occupancy counter merges simultaneous lane events against a parametrised capacity and drives the full/empty flags; the display path consumes occ_count.

Parameters:
N_LANES, 2, number of independent entry/exit lanes (1..8)
CAPACITY, 99, maximum occupancy; count saturates here
DEBOUNCE_CYCLES, 1_000_000, cycles a synchronised sensor level must be stable before acceptance (10 ms at 100 MHz)
TIMEOUT_CYCLES, 1_000_000_000, cycles a lane may stay mid-sequence before being declared faulted (10 s)
CNT_W, $clog2(CAPACITY+1), occupancy width (derived; do not override)

Ports:
clk  in  1  system clock, 100 MHz
rst_n  in  1  asynchronous active-low reset
s1  in  N_LANES  outer sensors, async, active-high
s2  in  N_LANES  inner sensors, async, active-high
clear  in  1  synchronous: occupancy forced to 0
occ_count  out  CNT_W  current occupancy
full  out  1  occ_count == CAPACITY
empty  out  1  occ_count == 0
lane_entry  out  N_LANES  one-cycle pulse per confirmed entry
lane_exit  out  N_LANES  one-cycle pulse per confirmed exit
lane_fault  out  N_LANES  level; lane timed out, cleared when both sensors are released
reject_full  out  1  one-cycle pulse; an entry was dropped by saturation
reject_empty  out  1  one-cycle pulse; an exit was dropped by saturation

Behaviour:
- Reset (async assert, sync release): occ_count=0, empty=1, full=0, all pulses and faults=0, lane FSMs in IDLE, debouncers hold 0.
- Input conditioning per sensor: 2-FF synchroniser, then debounce. The accepted level changes only after DEBOUNCE_CYCLES consecutive equal samples.
- Lane FSM, on debounced a=S1, b=S2:
  - IDLE: a&!b -> IN1; !a&b -> OUT1; a&b -> WAIT_CLEAR.
  - IN1: a&b -> IN2; !a&!b -> IDLE (back-out).
  - IN2: !a&b -> IN3; a&!b -> IN1; !a&!b -> IDLE.
  - IN3: !a&!b -> IDLE and lane_entry pulse; a&b -> IN2.
  - OUT1/OUT2/OUT3 mirror IN1..IN3 with a and b swapped; OUT3 -> IDLE fires lane_exit.
  - WAIT_CLEAR: !a&!b -> IDLE. No event is generated.
  - Pulses are registered and high the cycle after the FSM observes the clearing condition.
- Timeout: a per-lane counter runs in any state other than IDLE/WAIT_CLEAR and resets on every state change. At TIMEOUT_CYCLES-1 the lane goes to WAIT_CLEAR and sets lane_fault. lane_fault clears on WAIT_CLEAR -> IDLE.
- Occupancy update, once per cycle:
  - n_in = popcount(lane_entry), n_out = popcount(lane_exit).
  - next = occ_count + n_in - n_out, computed signed at CNT_W+4 bits.
  - Clamp to [0, CAPACITY]. reject_full pulses if next > CAPACITY; reject_empty pulses if next < 0.
  - Latency: occ_count changes the cycle after the lane pulse. full and empty are combinational from occ_count.
- Simultaneous events: entries and exits in the same cycle net out before clamping. Example: count=CAPACITY with 1 entry and 1 exit gives CAPACITY and no reject.
- clear takes priority over lane events in the same cycle (events discarded, no reject). It does not affect lane FSMs.
- Reset mid-sequence: the lane returns to IDLE. A half-completed pass produces no event after release.

Decomposition:
- Package parking_pkg: lane_state_t enum (IDLE, IN1, IN2, IN3, OUT1, OUT2, OUT3, WAIT_CLEAR) and a popcount function.
- Sub-module lane_direction_fsm: contains the synchroniser, debouncers, lane FSM and timeout for one lane. Parameters DEBOUNCE_CYCLES and TIMEOUT_CYCLES. It is instantiated N_LANES times via generate.
- The top level holds the merge/saturation counter.

Test Plan:
- Bench settings: DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=200, CAPACITY=5, N_LANES=2.
- Lane0 full entry sequence (S1, S1&S2, S2, none), each step held 10 cycles -> one lane_entry[0] pulse; occ_count 0->1 the next cycle; empty drops.
- Lane0 back-out (S1, S1&S2, S1, none) -> no pulses, occ_count unchanged; 2-cycle glitches on S1 in IDLE -> no state change.
- Preload 5 entries, then a 6th entry -> occ_count stays 5, full=1, reject_full pulses once. From 0, one exit -> reject_empty pulses, count stays 0.
- Same-cycle lane0 entry and lane1 exit at count=5 -> count stays 5, no reject. Same-cycle double entry at count=4 -> count=5, reject_full=1.
- Lane1 holds S1 only for 250 cycles -> lane_fault[1]=1 at timeout; release -> fault clears, no event. Assert rst_n low mid-IN2 -> all outputs at reset values immediately, no event after release.
